// File: rtl/store_queue_unit.sv
// -----------------------------------------------------------------------------
// store_queue_unit
// Buffered store unit for the memory stage. Committed stores come in over a
// valid/ready handshake and are checked for alignment. Their data is steered
// into byte lanes with a per-byte write mask. They are then held in a
// DEPTH-entry FIFO and drained to data memory over a request/acknowledge
// handshake. Loads that target a word with a pending store are flagged.
//
// Ports
//   clk_in, rst_n_in        clock (rising edge), async active-low reset
//   st_valid_in/ready_out   store handshake; ready is !full
//   fun_3_in                store size (SB/SH/SW/SD)
//   iadder_in, rs2_in       store byte address, right-justified store data
//   fault_out               one-cycle pulse after a rejected store
//   ld_chk_addr_in          load address to check against queued stores
//   ld_hazard_out           queued store hits the load's aligned word
//   dm_wr_req_o/dm_ack_in   head-of-queue write request / memory accept
//   dm_addr_o/data_o/mask_o head entry contents (zero when empty)
//   count_out, empty_out    occupancy status
// -----------------------------------------------------------------------------
module store_queue_unit #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     st_valid_in,
  output logic                     st_ready_out,
  input  logic [2:0]               fun_3_in,
  input  logic [XLEN-1:0]          iadder_in,
  input  logic [XLEN-1:0]          rs2_in,
  output logic                     fault_out,
  input  logic [XLEN-1:0]          ld_chk_addr_in,
  output logic                     ld_hazard_out,
  output logic                     dm_wr_req_o,
  input  logic                     dm_ack_in,
  output logic [XLEN-1:0]          dm_addr_o,
  output logic [XLEN-1:0]          dm_data_o,
  output logic [XLEN/8-1:0]        dm_wr_mask_o,
  output logic [$clog2(DEPTH):0]   count_out,
  output logic                     empty_out
);

  localparam int MW   = XLEN / 8;
  localparam int OFFW = $clog2(MW);
  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;

  // Replicate each mask bit across its byte lane.
  function automatic logic [XLEN-1:0] expand_mask(input logic [MW-1:0] m);
    logic [XLEN-1:0] r;
    r = {XLEN{1'b0}};
    for (int i = 0; i < MW; i++) begin
      r[8*i +: 8] = {8{m[i]}};
    end
    return r;
  endfunction

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            fault_q, fault_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [XLEN-1:0] ent_addr_q [DEPTH];
  logic [XLEN-1:0] ent_addr_d [DEPTH];
  logic [XLEN-1:0] ent_data_q [DEPTH];
  logic [XLEN-1:0] ent_data_d [DEPTH];
  logic [MW-1:0]   ent_mask_q [DEPTH];
  logic [MW-1:0]   ent_mask_d [DEPTH];

  logic [OFFW-1:0] off_s;
  logic [OFFW-1:0] align_mask_s;
  logic [MW-1:0]   size_mask_s;
  logic            legal_s;
  logic            ok_s;
  logic [XLEN-1:0] st_addr_s;
  logic [XLEN-1:0] st_data_s;
  logic [MW-1:0]   st_mask_s;
  logic            full_s;
  logic            empty_s;
  logic            push_s;
  logic            reject_s;
  logic            pop_s;
  logic [XLEN-1:0] ld_line_s;

  // Decode store size, check alignment and build the lane-steered entry.
  always_comb begin
    off_s        = iadder_in[OFFW-1:0];
    legal_s      = 1'b0;
    size_mask_s  = {MW{1'b0}};
    align_mask_s = {OFFW{1'b0}};
    case (fun_3_in)
      3'b000: begin
        legal_s     = 1'b1;
        size_mask_s = MW'(1'b1);
      end
      3'b001: begin
        legal_s      = 1'b1;
        size_mask_s  = MW'(2'b11);
        align_mask_s = OFFW'(1'b1);
      end
      3'b010: begin
        legal_s      = 1'b1;
        size_mask_s  = MW'(4'hF);
        align_mask_s = OFFW'(2'b11);
      end
      3'b011: begin
        // Doubleword stores only exist on the 64-bit datapath.
        if (XLEN == 64) begin
          legal_s      = 1'b1;
          size_mask_s  = {MW{1'b1}};
          align_mask_s = OFFW'(3'b111);
        end else begin
          legal_s = 1'b0;
        end
      end
      default: begin
        legal_s = 1'b0;
      end
    endcase
    ok_s      = legal_s && ((off_s & align_mask_s) == {OFFW{1'b0}});
    st_addr_s = {iadder_in[XLEN-1:OFFW], {OFFW{1'b0}}};
    st_data_s = (rs2_in & expand_mask(size_mask_s)) << {off_s, 3'b000};
    st_mask_s = size_mask_s << off_s;
  end

  // Handshake qualification; ready depends only on registered occupancy.
  always_comb begin
    full_s   = (count_q == CW'(DEPTH));
    empty_s  = (count_q == {CW{1'b0}});
    push_s   = st_valid_in && !full_s && ok_s;
    reject_s = st_valid_in && !full_s && !ok_s;
    pop_s    = dm_ack_in && !empty_s;
  end

  // Next-state for pointers, occupancy, valid bits, fault pulse and entries.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    valid_d    = valid_q;
    fault_d    = reject_s;
    ent_addr_d = ent_addr_q;
    ent_data_d = ent_data_q;
    ent_mask_d = ent_mask_q;
    if (push_s) begin
      wr_ptr_d             = wr_ptr_q + PW'(1'b1);
      valid_d[wr_ptr_q]    = 1'b1;
      ent_addr_d[wr_ptr_q] = st_addr_s;
      ent_data_d[wr_ptr_q] = st_data_s;
      ent_mask_d[wr_ptr_q] = st_mask_s;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    // Push and pop never target the same slot: push needs !full, pop needs !empty.
    if (pop_s) begin
      rd_ptr_d          = rd_ptr_q + PW'(1'b1);
      valid_d[rd_ptr_q] = 1'b0;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1'b1);
      2'b01:   count_d = count_q - CW'(1'b1);
      default: count_d = count_q;
    endcase
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
      valid_q  <= {DEPTH{1'b0}};
      fault_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_addr_q[i] <= {XLEN{1'b0}};
        ent_data_q[i] <= {XLEN{1'b0}};
        ent_mask_q[i] <= {MW{1'b0}};
      end
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      fault_q    <= fault_d;
      ent_addr_q <= ent_addr_d;
      ent_data_q <= ent_data_d;
      ent_mask_q <= ent_mask_d;
    end
  end

  // Load hazard: compare the load's aligned word against every valid entry.
  always_comb begin
    ld_line_s     = {ld_chk_addr_in[XLEN-1:OFFW], {OFFW{1'b0}}};
    ld_hazard_out = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (ent_addr_q[i] == ld_line_s)) begin
        ld_hazard_out = 1'b1;
      end else begin
        ld_hazard_out = ld_hazard_out;
      end
    end
  end

  // Output view of the head entry, zeroed when the queue is empty.
  always_comb begin
    st_ready_out = !full_s;
    fault_out    = fault_q;
    count_out    = count_q;
    empty_out    = empty_s;
    dm_wr_req_o  = !empty_s;
    if (empty_s) begin
      dm_addr_o    = {XLEN{1'b0}};
      dm_data_o    = {XLEN{1'b0}};
      dm_wr_mask_o = {MW{1'b0}};
    end else begin
      dm_addr_o    = ent_addr_q[rd_ptr_q];
      dm_data_o    = ent_data_q[rd_ptr_q];
      dm_wr_mask_o = ent_mask_q[rd_ptr_q];
    end
  end

endmodule

// File: tb/tb_store_queue_unit.sv
// -----------------------------------------------------------------------------
// tb_store_queue_unit
// Directed bench for store_queue_unit with one 32-bit/4-deep instance and one
// 64-bit/4-deep instance sharing clock and reset. Each task drives one
// scenario and checks outputs against hand-computed values one time unit after
// the rising edge.
// -----------------------------------------------------------------------------
module tb_store_queue_unit;

  logic clk;
  logic rst_n;

  // 32-bit instance signals
  logic        v32, rdy32, flt32, hz32, req32, ack32, emp32;
  logic [2:0]  f32;
  logic [31:0] a32, d32, ld32, oa32, od32;
  logic [3:0]  om32;
  logic [2:0]  cnt32;

  // 64-bit instance signals
  logic        v64, rdy64, flt64, hz64, req64, ack64, emp64;
  logic [2:0]  f64;
  logic [63:0] a64, d64, ld64, oa64, od64;
  logic [7:0]  om64;
  logic [2:0]  cnt64;

  int checks;
  int fails;

  store_queue_unit #(.XLEN(32), .DEPTH(4)) u_dut32 (
    .clk_in(clk), .rst_n_in(rst_n),
    .st_valid_in(v32), .st_ready_out(rdy32), .fun_3_in(f32),
    .iadder_in(a32), .rs2_in(d32), .fault_out(flt32),
    .ld_chk_addr_in(ld32), .ld_hazard_out(hz32),
    .dm_wr_req_o(req32), .dm_ack_in(ack32), .dm_addr_o(oa32),
    .dm_data_o(od32), .dm_wr_mask_o(om32), .count_out(cnt32), .empty_out(emp32)
  );

  store_queue_unit #(.XLEN(64), .DEPTH(4)) u_dut64 (
    .clk_in(clk), .rst_n_in(rst_n),
    .st_valid_in(v64), .st_ready_out(rdy64), .fun_3_in(f64),
    .iadder_in(a64), .rs2_in(d64), .fault_out(flt64),
    .ld_chk_addr_in(ld64), .ld_hazard_out(hz64),
    .dm_wr_req_o(req64), .dm_ack_in(ack64), .dm_addr_o(oa64),
    .dm_data_o(od64), .dm_wr_mask_o(om64), .count_out(cnt64), .empty_out(emp64)
  );

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  // Present one store to the 32-bit instance for a single clock edge.
  task automatic push32(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    v32 = 1'b1; f32 = f; a32 = a; d32 = d;
    @(posedge clk); #1;
    v32 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++; if (emp32 !== 1'b1) begin fails++; $display("FAIL reset_empty: got %b expected 1", emp32); end
    checks++; if (rdy32 !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b expected 1", rdy32); end
    checks++; if (req32 !== 1'b0) begin fails++; $display("FAIL reset_req: got %b expected 0", req32); end
    checks++; if (cnt32 !== 3'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", cnt32); end
    checks++; if ({oa32, od32, om32} !== 68'h0) begin fails++; $display("FAIL reset_head: got %h expected 0", {oa32, od32, om32}); end
    checks++; if (flt32 !== 1'b0 || hz32 !== 1'b0) begin fails++; $display("FAIL reset_flags: got fault %b hazard %b expected 0 0", flt32, hz32); end
    checks++; if (emp64 !== 1'b1 || req64 !== 1'b0) begin fails++; $display("FAIL reset_64: got empty %b req %b expected 1 0", emp64, req64); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_sb_steering();
    push32(3'b000, 32'h0000_1003, 32'hAABB_CCDD);
    checks++; if (req32 !== 1'b1) begin fails++; $display("FAIL sb_req: got %b expected 1", req32); end
    checks++; if (oa32 !== 32'h0000_1000) begin fails++; $display("FAIL sb_addr: got %h expected 00001000", oa32); end
    checks++; if (od32 !== 32'hDD00_0000) begin fails++; $display("FAIL sb_data: got %h expected dd000000", od32); end
    checks++; if (om32 !== 4'b1000) begin fails++; $display("FAIL sb_mask: got %b expected 1000", om32); end
    checks++; if (cnt32 !== 3'd1) begin fails++; $display("FAIL sb_count: got %0d expected 1", cnt32); end
    // SH at offset 2 lands in the upper half.
    ack32 = 1'b1;
    @(posedge clk); #1;
    ack32 = 1'b0;
    push32(3'b001, 32'h0000_1006, 32'h1234_5678);
    checks++; if (od32 !== 32'h5678_0000 || om32 !== 4'b1100) begin fails++; $display("FAIL sh_lane: got %h/%b expected 56780000/1100", od32, om32); end
    ack32 = 1'b1;
    @(posedge clk); #1;
    ack32 = 1'b0;
    checks++; if (emp32 !== 1'b1) begin fails++; $display("FAIL sb_drained: got %b expected 1", emp32); end
  endtask

  task automatic test_fault();
    push32(3'b001, 32'h0000_2001, 32'h0000_FFFF);
    checks++; if (flt32 !== 1'b1) begin fails++; $display("FAIL sh_mis_fault: got %b expected 1", flt32); end
    checks++; if (cnt32 !== 3'd0) begin fails++; $display("FAIL sh_mis_count: got %0d expected 0", cnt32); end
    @(posedge clk); #1;
    checks++; if (flt32 !== 1'b0) begin fails++; $display("FAIL fault_pulse_len: got %b expected 0", flt32); end
    push32(3'b011, 32'h0000_0000, 32'h1111_1111);
    checks++; if (flt32 !== 1'b1 || cnt32 !== 3'd0) begin fails++; $display("FAIL sd_on_32: got fault %b count %0d expected 1 0", flt32, cnt32); end
    push32(3'b100, 32'h0000_0000, 32'h1111_1111);
    checks++; if (flt32 !== 1'b1 || req32 !== 1'b0) begin fails++; $display("FAIL illegal_f3: got fault %b req %b expected 1 0", flt32, req32); end
    @(posedge clk); #1;
  endtask

  task automatic test_xlen64();
    v64 = 1'b1; f64 = 3'b011; a64 = 64'h10; d64 = 64'h0123_4567_89AB_CDEF;
    @(posedge clk); #1;
    v64 = 1'b0;
    checks++; if (om64 !== 8'hFF) begin fails++; $display("FAIL sd_mask: got %h expected ff", om64); end
    checks++; if (od64 !== 64'h0123_4567_89AB_CDEF || oa64 !== 64'h10) begin fails++; $display("FAIL sd_data: got %h @%h expected 0123456789abcdef @10", od64, oa64); end
    ack64 = 1'b1;
    @(posedge clk); #1;
    ack64 = 1'b0;
    v64 = 1'b1; f64 = 3'b010; a64 = 64'h14;
    @(posedge clk); #1;
    v64 = 1'b0;
    checks++; if (om64 !== 8'hF0) begin fails++; $display("FAIL sw64_mask: got %h expected f0", om64); end
    checks++; if (od64 !== 64'h89AB_CDEF_0000_0000 || oa64 !== 64'h10) begin fails++; $display("FAIL sw64_data: got %h @%h expected 89abcdef00000000 @10", od64, oa64); end
    ack64 = 1'b1;
    @(posedge clk); #1;
    ack64 = 1'b0;
    v64 = 1'b1; f64 = 3'b011; a64 = 64'h14;
    @(posedge clk); #1;
    v64 = 1'b0;
    checks++; if (flt64 !== 1'b1 || cnt64 !== 3'd0) begin fails++; $display("FAIL sd_mis: got fault %b count %0d expected 1 0", flt64, cnt64); end
    @(posedge clk); #1;
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) begin
      push32(3'b010, 32'h100 + 32'(4 * i), 32'h1111_1111 * 32'(i + 1));
    end
    checks++; if (rdy32 !== 1'b0 || cnt32 !== 3'd4) begin fails++; $display("FAIL full_ready: got ready %b count %0d expected 0 4", rdy32, cnt32); end
    push32(3'b010, 32'h200, 32'hDEAD_BEEF);
    checks++; if (cnt32 !== 3'd4 || oa32 !== 32'h100) begin fails++; $display("FAIL fifth_held: got count %0d head %h expected 4 100", cnt32, oa32); end
    ack32 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (oa32 !== 32'h100 + 32'(4 * i) || od32 !== 32'h1111_1111 * 32'(i + 1) || cnt32 !== 3'(4 - i)) begin
        fails++;
        $display("FAIL drain_%0d: got %h/%h count %0d expected %h/%h count %0d", i, oa32, od32, cnt32,
                 32'h100 + 32'(4 * i), 32'h1111_1111 * 32'(i + 1), 4 - i);
      end
      @(posedge clk); #1;
    end
    ack32 = 1'b0;
    checks++; if (cnt32 !== 3'd0 || emp32 !== 1'b1 || req32 !== 1'b0 || rdy32 !== 1'b1) begin fails++; $display("FAIL drain_end: got count %0d empty %b req %b ready %b expected 0 1 0 1", cnt32, emp32, req32, rdy32); end
  endtask

  task automatic test_hazard();
    push32(3'b010, 32'h0000_3004, 32'h0000_00AA);
    ld32 = 32'h0000_3006; #1;
    checks++; if (hz32 !== 1'b1) begin fails++; $display("FAIL hazard_hit: got %b expected 1", hz32); end
    ld32 = 32'h0000_3008; #1;
    checks++; if (hz32 !== 1'b0) begin fails++; $display("FAIL hazard_miss: got %b expected 0", hz32); end
    ack32 = 1'b1;
    @(posedge clk); #1;
    ack32 = 1'b0;
    ld32 = 32'h0000_3006; #1;
    checks++; if (hz32 !== 1'b0) begin fails++; $display("FAIL hazard_after_pop: got %b expected 0", hz32); end
  endtask

  task automatic test_back_to_back();
    push32(3'b010, 32'h400, 32'hA0);
    push32(3'b010, 32'h404, 32'hA1);
    push32(3'b010, 32'h408, 32'hA2);
    checks++; if (cnt32 !== 3'd3) begin fails++; $display("FAIL b2b_fill: got %0d expected 3", cnt32); end
    v32 = 1'b1; f32 = 3'b010; a32 = 32'h40C; d32 = 32'hA3; ack32 = 1'b1;
    @(posedge clk); #1;
    v32 = 1'b0; ack32 = 1'b0;
    checks++; if (cnt32 !== 3'd3 || oa32 !== 32'h404 || od32 !== 32'hA1) begin fails++; $display("FAIL b2b_pushpop: got count %0d head %h/%h expected 3 404/a1", cnt32, oa32, od32); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (emp32 !== 1'b1 || req32 !== 1'b0 || cnt32 !== 3'd0 || oa32 !== 32'h0) begin fails++; $display("FAIL midreset: got empty %b req %b count %0d addr %h expected 1 0 0 0", emp32, req32, cnt32, oa32); end
    ack32 = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    ack32 = 1'b0;
    checks++; if (cnt32 !== 3'd0 || req32 !== 1'b0 || rdy32 !== 1'b1) begin fails++; $display("FAIL ack_after_reset: got count %0d req %b ready %b expected 0 0 1", cnt32, req32, rdy32); end
  endtask

  // Scenario sequencer.
  initial begin
    checks = 0; fails = 0;
    clk = 1'b0; rst_n = 1'b0;
    v32 = 1'b0; f32 = 3'b000; a32 = 32'h0; d32 = 32'h0; ld32 = 32'h0; ack32 = 1'b0;
    v64 = 1'b0; f64 = 3'b000; a64 = 64'h0; d64 = 64'h0; ld64 = 64'h0; ack64 = 1'b0;
    test_reset();
    test_sb_steering();
    test_fault();
    test_xlen64();
    test_full();
    test_hazard();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/store_queue_unit.md
# store_queue_unit

Parametrised, buffered store unit for the RV core's memory stage. It accepts committed stores from the execute/commit path over a valid/ready handshake and checks alignment. It steers the store data into byte lanes with a per-byte write mask, queues the stores in a DEPTH-entry FIFO, and drains them to data memory over a request/acknowledge handshake. It also flags loads that would hit a pending store.

## Interface
- XLEN, 32: data/address width; legal values 32 or 64.
- DEPTH, 4: queue entries; power of two, at least 2.
- clk_in  input  1  clock, rising edge.
- rst_n_in  input  1  reset, asynchronous, active-low.
- st_valid_in  input  1  store request valid.
- st_ready_out  output  1  queue can accept a store; equals the inverse of full.
- fun_3_in  input  3  store size: 000 SB, 001 SH, 010 SW, 011 SD (SD is legal only when XLEN=64).
- iadder_in  input  XLEN  store byte address.
- rs2_in  input  XLEN  store source data, right-justified.
- fault_out  output  1  one-cycle pulse: misaligned or illegal store was rejected.
- ld_chk_addr_in  input  XLEN  address of the load being issued.
- ld_hazard_out  output  1  a queued store targets the same XLEN-aligned word.
- dm_wr_req_o  output  1  head entry valid, write requested.
- dm_ack_in  input  1  memory accepted the head write.
- dm_addr_o  output  XLEN  head address with the low log2(XLEN/8) bits cleared.
- dm_data_o  output  XLEN  head data, lane-steered.
- dm_wr_mask_o  output  XLEN/8  head per-byte write enable.
- count_out  output  $clog2(DEPTH)+1  occupied entries.
- empty_out  output  1  queue empty.

## Operation
- Offset: off = iadder_in[log2(XLEN/8)-1:0].
- Alignment rules:
  - SB: always legal.
  - SH: off[0]=0.
  - SW: off[1:0]=0.
  - SD: off[2:0]=0 and XLEN=64.
  - Any other fun_3_in, or SD at XLEN=32, is illegal.
- Handshake: a transfer occurs when st_valid_in && st_ready_out.
  - Legal transfer: the entry is enqueued.
  - Illegal or misaligned transfer: nothing is enqueued, and fault_out=1 on the following cycle only.
- Lane steering, where n = size in bytes:
  - data = rs2_in[8n-1:0] << (8·off); all other bytes are zero.
  - mask = ((1<<n)-1) << off.
- Entry contents: {aligned address, data, mask}.
- Head: dm_wr_req_o = !empty. dm_addr_o, dm_data_o and dm_wr_mask_o show the head entry and stay stable until dm_ack_in. They are driven to zero when empty.
- Pop: dm_ack_in && dm_wr_req_o pops the head. dm_ack_in while empty is ignored.
- Hazard: ld_hazard_out is purely combinational. It is 1 when any valid entry's aligned address equals ld_chk_addr_in with its low log2(XLEN/8) bits cleared.
- Simultaneous push and pop: the count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.
- Full: count = DEPTH, which forces st_ready_out=0. There is no combinational path from dm_ack_in to st_ready_out.

## Timing
- Reset values (asynchronous, while rst_n_in=0):
  - pointers and count 0; empty_out=1; st_ready_out=1.
  - dm_wr_req_o=0; dm_addr_o, dm_data_o, dm_wr_mask_o = 0.
  - fault_out=0; ld_hazard_out=0.
- Reset assertion mid-drain discards all entries immediately. A dm_ack_in arriving after reset is ignored.
- Latency from accept to dm_wr_req_o is 1 cycle when the queue was empty.
- Pop-to-next-head: a new head is visible on the cycle after the ack edge, so back-to-back acks retire one entry per cycle.
- fault_out is registered: 1 cycle after the rejected transfer.
- Stores are written to memory in FIFO order.

## Test plan
- SB, XLEN=32, iadder_in=0x1003, rs2_in=0xAABBCCDD → one cycle later: dm_addr_o=0x1000, dm_data_o=0xDD000000, dm_wr_mask_o=4'b1000.
- SH at iadder_in=0x2001 → fault_out pulses 1 cycle, count_out stays 0. SD with XLEN=32 → fault_out pulses.
- XLEN=64, SD at 0x10, rs2_in=0x0123456789ABCDEF → dm_wr_mask_o=8'hFF, full data unchanged. SW at 0x14 → mask 8'hF0, data in the upper word.
- DEPTH=4, hold dm_ack_in=0 and push 5 stores → st_ready_out=0 after the 4th and the 5th is held. Then ack every cycle → four writes in order, count_out 4→0, empty_out=1.
- Store queued at 0x3004 (XLEN=32) → ld_chk_addr_in=0x3006 gives ld_hazard_out=1; 0x3008 gives 0. After the ack, 0x3006 gives 0.
- Queue at 3 entries, simultaneous push and ack → count_out stays 3. Assert rst_n_in mid-sequence → empty_out=1 and dm_wr_req_o=0 immediately.
